// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding, oversampling constants and the
// three-sample majority vote used by the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;   // vote window is SAMPLE_MID-1 .. SAMPLE_MID+1

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-stage synchronizer for an asynchronous single-bit input; resets to 1 so an
// idle-high line does not look like activity while coming out of reset.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the values from before the clock edge, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, majority-voted bits, LSB first, valid/ready
// output with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rx,
    input  logic                 ready_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [3:0]    CNT_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]    CNT_VOTE0 = 4'(SAMPLE_MID - 1);
    localparam logic [3:0]    CNT_VOTE1 = 4'(SAMPLE_MID);
    localparam logic [3:0]    CNT_VOTE2 = 4'(SAMPLE_MID + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t          state;
    logic [3:0]           cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 stop_bad;
    logic                 samp_a;
    logic                 samp_b;
    logic                 bit_vote;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;

    uart_sync #(.STAGES(2)) u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (rx),
        .q     (rx_s)
    );

    logic vote_now;
    logic maj;
    logic frame_end;
    logic frame_good;

    always_comb begin
        vote_now   = (cnt == CNT_VOTE2);
        maj        = majority3(samp_a, samp_b, rx_s);
        // The final stop bit ends the frame at its vote, not at its end, so a
        // start bit that immediately follows still finds the receiver idle.
        frame_end  = (state == ST_STOP) && vote_now && (stop_cnt == LAST_STOP);
        frame_good = frame_end && !stop_bad && maj;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            stop_bad  <= 1'b0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            bit_vote  <= 1'b1;
            shreg     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (cnt == CNT_VOTE0) samp_a <= rx_s;
            if (cnt == CNT_VOTE1) samp_b <= rx_s;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= ST_START;
                end
                ST_START: begin
                    cnt <= cnt + 4'd1;
                    if (vote_now && maj) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    cnt <= cnt + 4'd1;
                    if (vote_now) bit_vote <= maj;
                    if (cnt == CNT_LAST) begin
                        shreg <= {bit_vote, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state    <= ST_STOP;
                            stop_cnt <= 1'b0;
                            stop_bad <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    cnt <= cnt + 4'd1;
                    if (vote_now && !maj) stop_bad <= 1'b1;
                    if (frame_end) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase

            // A word loading in the same cycle as a handshake replaces the
            // consumed one, so it is neither an overrun nor a drop of valid.
            if (frame_good) begin
                data_out  <= shreg;
                valid_out <= 1'b1;
                overrun   <= valid_out && !ready_in;
            end else begin
                if (frame_end) frame_err <= 1'b1;
                if (valid_out && ready_in) valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural transmitter drives rx, expected
// words are queued at send time and popped on every valid/ready handshake.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rx;
    logic       ready_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int err_cnt  = 0;
    int ovr_cnt  = 0;
    int hs_cnt   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(.DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rx        (rx),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Monitor samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (n_rst) begin
            if (frame_err) err_cnt++;
            if (overrun)   ovr_cnt++;
            if (valid_out && ready_in) begin
                hs_cnt++;
                if (exp_q.size() == 0) check("extra_word", 32'(exp_q.size()), 32'd1);
                else                   check("data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        step(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int glitch_bit);
        drive_bit(1'b0, OVERSAMPLE);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                drive_bit(d[i], 9);
                drive_bit(~d[i], 1);
                drive_bit(d[i], 6);
            end else begin
                drive_bit(d[i], OVERSAMPLE);
            end
        end
        drive_bit(stop_val, OVERSAMPLE);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            step(1);
            t++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        n_rst    = 1'b0;
        rx       = 1'b1;
        ready_in = 1'b1;
        #1;
        check("rst_data",  {24'd0, data_out}, 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_ferr",  32'(frame_err), 32'd0);
        check("rst_ovr",   32'(overrun), 32'd0);
        step(3);
        n_rst = 1'b1;
        step(5);

        // Basic word with the consumer always ready.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1);
        step(20);
        wait_drain("drain_a5");
        check("a5_ferr", 32'(err_cnt), 32'd0);
        check("a5_ovr",  32'(ovr_cnt), 32'd0);
        check("a5_hs",   32'(hs_cnt), 32'd1);

        // Short low pulse is rejected as a false start.
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        check("fs_state", 32'(dut.state), 32'(ST_IDLE));
        check("fs_valid", 32'(valid_out), 32'd0);
        check("fs_hs",    32'(hs_cnt), 32'd1);

        // Low stop bit: frame error, no word, then recovery.
        send_frame(8'h3C, 1'b0, -1);
        step(40);
        check("bad_ferr",  32'(err_cnt), 32'd1);
        check("bad_valid", 32'(valid_out), 32'd0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1);
        step(20);
        wait_drain("drain_55");

        // Back-to-back frames with no idle gap.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        step(20);
        wait_drain("drain_b2b");
        check("b2b_ferr", 32'(err_cnt), 32'd1);
        check("b2b_hs",   32'(hs_cnt), 32'd4);

        // Overrun: consumer stalled across two words.
        ready_in = 1'b0;
        send_frame(8'h11, 1'b1, -1);
        step(10);
        check("ovr_first_valid", 32'(valid_out), 32'd1);
        check("ovr_first_data",  {24'd0, data_out}, 32'h11);
        send_frame(8'h22, 1'b1, -1);
        step(10);
        check("ovr_cnt",   32'(ovr_cnt), 32'd1);
        check("ovr_valid", 32'(valid_out), 32'd1);
        check("ovr_data",  {24'd0, data_out}, 32'h22);
        exp_q.push_back(8'h22);
        ready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_clear", 32'(valid_out), 32'd0);
        step(1);
        wait_drain("drain_ovr");

        // Single-cycle glitch in the middle of data bit 3 is outvoted.
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, 3);
        step(20);
        wait_drain("drain_glitch");

        // Asynchronous reset in the middle of a frame.
        ready_in = 1'b0;
        send_frame(8'h5A, 1'b1, -1);
        step(10);
        check("pre_rst_valid", 32'(valid_out), 32'd1);
        check("pre_rst_data",  {24'd0, data_out}, 32'h5A);
        drive_bit(1'b0, OVERSAMPLE);
        drive_bit(1'b1, OVERSAMPLE);
        drive_bit(1'b1, 8);
        n_rst = 1'b0;
        #1;
        check("mid_rst_data",  {24'd0, data_out}, 32'd0);
        check("mid_rst_valid", 32'(valid_out), 32'd0);
        check("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
        rx = 1'b1;
        step(2);
        n_rst    = 1'b1;
        ready_in = 1'b1;
        step(5);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1);
        step(20);
        wait_drain("drain_81");

        check("end_ferr", 32'(err_cnt), 32'd1);
        check("end_ovr",  32'(ovr_cnt), 32'd1);
        check("end_hs",   32'(hs_cnt), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
